cargo_serial_tx: RTL
====================

# cargo_serial_tx

Parametrised, synthesizable serial frame transmitter for SmartCargo cargo requests. Each request word encodes tipo_objeto, destino_objeto and origem_objeto. The block queues request words in a small FIFO and serialises each one onto an idle-high line: start bit, data bits LSB first, optional parity, then one or two stop bits. It drives the `RX` input of `smart_cargo` from a host console, remote panel or bench harness. It supersedes the ad-hoc unbuffered, fixed-format sender with a configurable bit rate, data width, parity mode and stop-bit count.

## Interface
Parameters:
- `DATA_W`, 7: request payload width in bits.
- `CLKS_PER_BIT`, 16: clk cycles per serial bit; must be ≥ 2.
- `PARITY`, 1: parity mode. 0 = none, 1 = odd (payload plus parity bit has an odd number of ones), 2 = even.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `FIFO_DEPTH`, 4: request queue depth; a power of two, ≥ 2.
- `DROP_ZERO`, 1: when 1, an all-zero payload is accepted and discarded, never transmitted.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `in_valid`, in, 1: request word present on `in_data`.
- `in_ready`, out, 1: block can accept a request this cycle.
- `in_data`, in, DATA_W: request payload.
- `flush`, in, 1: discard all queued, not-yet-started requests.
- `tx`, out, 1: serial line, idle high.
- `busy`, out, 1: a frame is in progress.
- `fifo_count`, out, $clog2(FIFO_DEPTH+1): number of queued requests.

## Operation
- A request is accepted on a clk edge where `in_valid && in_ready`.
- `in_ready = !reset && !flush && fifo_count < FIFO_DEPTH`. This is combinational from registered state. A push and a pop on the same edge are legal whenever the FIFO is not full.
- If `DROP_ZERO` = 1 and `in_data` = 0, the request is accepted but not written to the FIFO, and `fifo_count` does not change.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE, FIFO non-empty: pop the head into the shift register, drive `tx` = 0, go to START.
  - START to DATA: after CLKS_PER_BIT cycles. Bit index is 0.
  - DATA: `tx` = shift[idx]. After DATA_W bit periods, go to PAR if `PARITY` ≠ 0, else go to STOP.
  - PAR: `tx` = ^payload for even mode, or ~^payload for odd mode.
  - STOP: `tx` = 1 for STOP_BITS × CLKS_PER_BIT cycles. At the final edge, pop and go to START if the FIFO is non-empty; otherwise go to IDLE.
- The baud counter runs from 0 to CLKS_PER_BIT-1 and reloads at each bit boundary. Width is $clog2(CLKS_PER_BIT). The bit index has width $clog2(DATA_W+1).
- `busy` = (state ≠ IDLE).
- `flush`:
  - Resets the FIFO pointers and count on the next edge.
  - The frame in flight completes unchanged.
  - A push offered in the same cycle is refused, because `in_ready` is 0.
  - If `flush` coincides with an IDLE pop, the pop wins: that one word is transmitted and the rest are discarded.

## Timing
- Reset values: `tx` = 1, `busy` = 0, `fifo_count` = 0, `in_ready` = 0 while reset is high and 1 after release. FSM is in IDLE; pointers and counters are 0.
- Reset asserted mid-frame: `tx` returns to 1 immediately (asynchronously), and the queue is lost.
- Latency: for a request accepted at edge N into an empty FIFO while IDLE, `fifo_count` = 1 after edge N, and `tx` falls at edge N+1.
- Every bit lasts exactly CLKS_PER_BIT cycles.
- Frame length = (1 + DATA_W + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Back-to-back frames have zero idle cycles between the last stop bit and the next start bit.
- FIFO pointers wrap modulo FIFO_DEPTH. Full is detected by the count, not by pointer equality.

## Structure
- Shared package `cargo_serial_pkg`:
  - parity constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - FSM state typedef `tx_state_t`;
  - the default `CARGO_REQ_W` = 7.
- One sub-module, `cargo_tx_fifo`: a synchronous FIFO with push/pop/flush, `count` output and parameter `DEPTH`. The FSM and the shifter stay in the top level.

## Test plan
- Default parameters with CLKS_PER_BIT = 4; push 7'b0011100.
  - `tx` emits 0, 0,0,1,1,1,0,0, then parity 0, then stop 1. Each bit lasts 4 cycles; the frame is 40 cycles.
  - Start bit at acceptance edge + 1.
- DROP_ZERO = 1; push 0.
  - `in_ready` is 1 and the word is accepted.
  - `fifo_count` stays 0, `tx` stays 1 and `busy` stays 0 for 100 cycles.
- FIFO_DEPTH = 4; push 5 non-zero words on consecutive cycles.
  - `in_ready` is 0 once `fifo_count` = 4.
  - The fifth word is accepted after the first pop.
  - All 5 frames are transmitted contiguously with no idle gap.
- PARITY = 2, STOP_BITS = 2; push 7'h7F.
  - Parity bit = 1, followed by 2 stop bits; the frame is 11 × CLKS_PER_BIT cycles.
- Queue 3 words, then assert `flush` during the first frame's DATA state.
  - The first frame completes intact and `fifo_count` reads 0 on the next edge.
  - Line is idle afterwards and `busy` = 0.
- Assert `reset` mid-DATA.
  - `tx` = 1 and `busy` = 0 immediately; `fifo_count` = 0.
  - After release, a new push transmits correctly.

Source files
------------

// File: rtl/cargo_serial_pkg.sv
// Shared definitions for the cargo request serial transmitter: parity modes,
// FSM state encoding and the default request word width.
package cargo_serial_pkg;

  localparam int CARGO_REQ_W = 7;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/cargo_tx_fifo.sv
// Synchronous request FIFO with flush; full/empty are derived from the
// occupancy count so the pointers may simply wrap modulo DEPTH.
module cargo_tx_fifo
  import cargo_serial_pkg::*;
#(
  parameter int WIDTH = CARGO_REQ_W,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/cargo_serial_tx.sv
// Buffered serial frame transmitter for cargo requests: start bit, data LSB
// first, optional parity, one or two stop bits on an idle-high line.
module cargo_serial_tx
  import cargo_serial_pkg::*;
#(
  parameter int DATA_W       = CARGO_REQ_W,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = PAR_ODD,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int DROP_ZERO    = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            flush,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_W + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t         state, state_n;
  logic [BAUD_W-1:0] baud, baud_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic              stop_idx, stop_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic              par_q, par_n;
  logic              tx_q, tx_n;
  logic              load;
  logic              push;
  logic              fifo_empty;
  logic              fifo_full;
  logic [DATA_W-1:0] head;

  assign in_ready = !reset && !flush && !fifo_full;
  assign push     = in_valid && in_ready && !((DROP_ZERO != 0) && (in_data == '0));

  cargo_tx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (load),
    .flush (flush),
    .din   (in_data),
    .dout  (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      baud     <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      idx      <= idx_n;
      stop_idx <= stop_n;
      shift    <= shift_n;
      par_q    <= par_n;
      tx_q     <= tx_n;
    end
  end

  // tx is registered, so each branch sets the level for the bit that starts
  // on the coming edge; the load block below is shared by IDLE and the
  // final stop edge so back-to-back frames need no idle cycle.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    idx_n   = idx;
    stop_n  = stop_idx;
    shift_n = shift;
    par_n   = par_q;
    tx_n    = tx_q;
    load    = 1'b0;
    case (state)
      ST_IDLE: load = !fifo_empty;
      ST_START: begin
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          idx_n   = '0;
          tx_n    = shift[0];
          state_n = ST_DATA;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (idx == IDX_LAST) begin
            if (PARITY != PAR_NONE) begin
              state_n = ST_PAR;
              tx_n    = par_q;
            end else begin
              state_n = ST_STOP;
              tx_n    = 1'b1;
              stop_n  = 1'b0;
            end
          end else begin
            idx_n   = idx + 1'b1;
            shift_n = shift >> 1;
            tx_n    = shift[1];
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      ST_PAR: begin
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          state_n = ST_STOP;
          tx_n    = 1'b1;
          stop_n  = 1'b0;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (stop_idx == STOP_LAST) begin
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_n = ST_IDLE;
              tx_n    = 1'b1;
            end
          end else begin
            stop_n = 1'b1;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        tx_n    = 1'b1;
      end
    endcase
    if (load) begin
      shift_n = head;
      par_n   = (PARITY == PAR_EVEN) ? ^head : ~^head;
      tx_n    = 1'b0;
      baud_n  = '0;
      state_n = ST_START;
    end
  end

  assign tx   = tx_q;
  assign busy = (state != ST_IDLE);

endmodule
